// File: rtl/hall98_sequencer.sv
// rtl/hall98_sequencer.sv - instruction store and fetch/issue sequencer for the hall98 datapath
module hall98_sequencer #(
  parameter int PROG_DEPTH = 16,
  parameter int ADDR_W     = 4
) (
  input  logic              iclock,
  input  logic              irst_n,
  input  logic              start,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [39:0]       load_data,
  output logic              sw1,
  output logic              sw2,
  output logic              flag,
  output logic [31:0]       re,
  output logic [31:0]       n,
  output logic              issue,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic              err,
  output logic [7:0]        icount
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [39:0]       ir_q, ir_d;
  logic              err_q, err_d;
  logic [7:0]        icount_q, icount_d;
  logic              sw1_q, sw1_d;
  logic              sw2_q, sw2_d;
  logic              flag_q, flag_d;
  logic [31:0]       re_q, re_d;
  logic [31:0]       n_q, n_d;
  logic              issue_q, issue_d;
  logic              store_we;
  logic [39:0]       store_q [PROG_DEPTH];
  logic [3:0]        ir_reg;
  logic              reg_ok;

  assign ir_reg = ir_q[35:32];
  assign reg_ok = (ir_reg != 4'd0) && (ir_reg <= 4'd4);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    err_d    = err_q;
    icount_d = icount_q;
    sw1_d    = 1'b0;
    sw2_d    = 1'b0;
    flag_d   = 1'b1;
    re_d     = 32'd0;
    n_d      = 32'd0;
    issue_d  = 1'b0;
    store_we = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        // A load always wins over a simultaneous start.
        if (load_en) begin
          store_we = 1'b1;
        end else if (start) begin
          pc_d     = '0;
          err_d    = 1'b0;
          icount_d = 8'd0;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_d    = store_q[pc_q];
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (ir_q[36]) begin
          state_d = S_DONE;
        end else begin
          if (!reg_ok) begin
            err_d = 1'b1;
          end else begin
            sw1_d   = ir_q[39];
            sw2_d   = ir_q[38];
            flag_d  = ir_q[37];
            re_d    = {28'd0, ir_reg};
            n_d     = ir_q[31:0];
            issue_d = 1'b1;
            if (icount_q != 8'hFF) icount_d = icount_q + 8'd1;
          end
          if (pc_q == LAST_PC) begin
            state_d = S_DONE;
          end else begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iclock or negedge irst_n) begin
    if (!irst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ir_q     <= 40'd0;
      err_q    <= 1'b0;
      icount_q <= 8'd0;
      sw1_q    <= 1'b0;
      sw2_q    <= 1'b0;
      flag_q   <= 1'b1;
      re_q     <= 32'd0;
      n_q      <= 32'd0;
      issue_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      err_q    <= err_d;
      icount_q <= icount_d;
      sw1_q    <= sw1_d;
      sw2_q    <= sw2_d;
      flag_q   <= flag_d;
      re_q     <= re_d;
      n_q      <= n_d;
      issue_q  <= issue_d;
    end
  end

  // Program store survives reset so a host can reload only what changed.
  always_ff @(posedge iclock) begin
    if (store_we) store_q[load_addr] <= load_data;
  end

  assign sw1    = sw1_q;
  assign sw2    = sw2_q;
  assign flag   = flag_q;
  assign re     = re_q;
  assign n      = n_q;
  assign issue  = issue_q;
  assign busy   = (state_q == S_FETCH) || (state_q == S_ISSUE);
  assign done   = (state_q == S_DONE);
  assign pc     = pc_q;
  assign err    = err_q;
  assign icount = icount_q;

endmodule

// File: tb/tb_hall98_sequencer.sv
// tb/tb_hall98_sequencer.sv - scoreboard bench for hall98_sequencer
module tb_hall98_sequencer;

  localparam logic [66:0] IDLE_OUT = {2'b00, 1'b1, 64'd0};

  logic        iclock;
  logic        irst_n;
  logic        start;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [39:0] load_data;
  logic        sw1, sw2, flag, issue, busy, done, err;
  logic [31:0] re, n;
  logic [3:0]  pc;
  logic [7:0]  icount;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [39:0] model_mem [16];
  logic [66:0] exp_q [$];
  int          issue_log [$];
  logic [31:0] dp [8];

  hall98_sequencer #(.PROG_DEPTH(16), .ADDR_W(4)) dut (
    .iclock(iclock), .irst_n(irst_n), .start(start), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .sw1(sw1), .sw2(sw2),
    .flag(flag), .re(re), .n(n), .issue(issue), .busy(busy), .done(done),
    .pc(pc), .err(err), .icount(icount)
  );

  initial begin
    iclock = 1'b0;
    forever #5 iclock = ~iclock;
  end

  always @(posedge iclock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500us, required finish");
    $fatal(1);
  end

  function automatic logic [39:0] mk(input logic [1:0] op, input logic fl, input logic h,
                                     input logic [3:0] r, input logic [31:0] v);
    return {op, fl, h, r, v};
  endfunction

  // One cycle step: scoreboard compare of the datapath outputs plus a tiny datapath model.
  task automatic tick();
    logic [66:0] e;
    @(negedge iclock);
    if (irst_n) begin
      vectors++;
      if (issue) begin
        issue_log.push_back(cyc);
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_issue: got %h, required no issue", {sw1, sw2, flag, re, n});
        end else begin
          e = exp_q.pop_front();
          if ({sw1, sw2, flag, re, n} !== e) begin
            miscompares++;
            $display("FAIL issue_word: got %h, required %h", {sw1, sw2, flag, re, n}, e);
          end
        end
        if (!flag) begin
          case ({sw1, sw2})
            2'b10:   dp[re[2:0]] = n;
            2'b01:   dp[re[2:0]] = dp[re[2:0]] + dp[n[2:0]];
            2'b11:   dp[re[2:0]] = dp[re[2:0]] - dp[n[2:0]];
            default: dp[re[2:0]] = dp[re[2:0]] * dp[n[2:0]];
          endcase
        end
      end else if ({sw1, sw2, flag, re, n} !== IDLE_OUT) begin
        miscompares++;
        $display("FAIL idle_outputs: got %h, required %h", {sw1, sw2, flag, re, n}, IDLE_OUT);
      end
    end
  endtask

  task automatic load_word(input logic [3:0] a, input logic [39:0] d);
    tick();
    load_en = 1'b1; load_addr = a; load_data = d;
    model_mem[a] = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic load_basic();
    load_word(4'd0, mk(2'b10, 1'b0, 1'b0, 4'd1, 32'd5));
    load_word(4'd1, mk(2'b10, 1'b0, 1'b0, 4'd2, 32'd3));
    load_word(4'd2, mk(2'b01, 1'b0, 1'b0, 4'd1, 32'd2));
    load_word(4'd3, mk(2'b00, 1'b0, 1'b1, 4'd0, 32'd0));
  endtask

  task automatic push_expected();
    logic [39:0] w;
    for (int p = 0; p < 16; p++) begin
      w = model_mem[p];
      if (w[36]) break;
      if (w[35:32] >= 4'd1 && w[35:32] <= 4'd4)
        exp_q.push_back({w[39:38], w[37], 28'd0, w[35:32], w[31:0]});
    end
  endtask

  task automatic run_prog(input bit interfere, output int lat, output int gaps_bad, output int n_iss);
    int base;
    int sc;
    push_expected();
    base = issue_log.size();
    tick();
    start = 1'b1;
    sc = cyc;
    tick();
    start = 1'b0;
    if (interfere) begin
      load_en = 1'b1; load_addr = 4'd2; load_data = 40'hFF_FFFF_FFFF; start = 1'b1;
      tick();
      load_en = 1'b0; start = 1'b0;
    end
    for (int i = 0; i < 200 && !done; i++) tick();
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL run_timeout: done=%b after 200 cycles, required 1", done);
    end
    n_iss = issue_log.size() - base;
    lat = (n_iss > 0) ? issue_log[base] - sc : -1;
    gaps_bad = 0;
    for (int i = base + 1; i < issue_log.size(); i++)
      if (issue_log[i] - issue_log[i-1] != 2) gaps_bad++;
  endtask

  task automatic test_reset();
    irst_n = 1'b0; start = 1'b0; load_en = 1'b0; load_addr = 4'd0; load_data = 40'd0;
    tick();
    tick();
    vectors++;
    if ({sw1, sw2, flag, re, n, issue, busy, done, pc, err, icount} !==
        {1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0}) begin
      miscompares++;
      $display("FAIL reset_state: got sw=%b%b flag=%b re=%0d n=%0d issue=%b busy=%b done=%b pc=%0d err=%b icount=%0d, required 00 1 0 0 0 0 0 0 0 0",
               sw1, sw2, flag, re, n, issue, busy, done, pc, err, icount);
    end
    irst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat, gb, ni;
    load_basic();
    for (int i = 0; i < 8; i++) dp[i] = 32'd0;
    run_prog(1'b0, lat, gb, ni);
    vectors++;
    if ({done, busy, pc, icount, err} !== {1'b1, 1'b0, 4'd3, 8'd3, 1'b0}) begin
      miscompares++;
      $display("FAIL basic_status: got done=%b busy=%b pc=%0d icount=%0d err=%b, required 1 0 3 3 0",
               done, busy, pc, icount, err);
    end
    vectors++;
    if (ni !== 3 || lat !== 3 || gb !== 0) begin
      miscompares++;
      $display("FAIL basic_timing: got issues=%0d latency=%0d bad_gaps=%0d, required 3 3 0", ni, lat, gb);
    end
    vectors++;
    if (dp[1] !== 32'd8 || dp[2] !== 32'd3 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL basic_datapath: got H=%0d A=%0d pending=%0d, required 8 3 0", dp[1], dp[2], exp_q.size());
    end
  endtask

  task automatic test_restart();
    int lat, gb, ni;
    run_prog(1'b0, lat, gb, ni);
    vectors++;
    if ({done, pc, icount, err} !== {1'b1, 4'd3, 8'd3, 1'b0} || ni !== 3 || lat !== 3 || gb !== 0) begin
      miscompares++;
      $display("FAIL restart: got done=%b pc=%0d icount=%0d err=%b issues=%0d latency=%0d bad_gaps=%0d, required 1 3 3 0 3 3 0",
               done, pc, icount, err, ni, lat, gb);
    end
    vectors++;
    if (dp[1] !== 32'd8 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL restart_datapath: got H=%0d pending=%0d, required 8 0", dp[1], exp_q.size());
    end
  endtask

  task automatic test_illegal();
    int lat, gb, ni;
    load_word(4'd0, mk(2'b10, 1'b0, 1'b0, 4'd7, 32'd9));
    load_word(4'd1, mk(2'b00, 1'b0, 1'b1, 4'd0, 32'd0));
    run_prog(1'b0, lat, gb, ni);
    vectors++;
    if ({done, busy, pc, icount, err} !== {1'b1, 1'b0, 4'd1, 8'd0, 1'b1} || ni !== 0) begin
      miscompares++;
      $display("FAIL illegal_reg: got done=%b busy=%b pc=%0d icount=%0d err=%b issues=%0d, required 1 0 1 0 1 0",
               done, busy, pc, icount, err, ni);
    end
  endtask

  task automatic test_end_of_store();
    int lat, gb, ni;
    for (int k = 0; k < 16; k++) load_word(4'(k), mk(2'b10, 1'b0, 1'b0, 4'd4, 32'(k + 1)));
    run_prog(1'b0, lat, gb, ni);
    vectors++;
    if ({done, busy, pc, icount, err} !== {1'b1, 1'b0, 4'd15, 8'd16, 1'b0}) begin
      miscompares++;
      $display("FAIL eos_status: got done=%b busy=%b pc=%0d icount=%0d err=%b, required 1 0 15 16 0",
               done, busy, pc, icount, err);
    end
    vectors++;
    if (ni !== 16 || lat !== 3 || gb !== 0 || dp[4] !== 32'd16) begin
      miscompares++;
      $display("FAIL eos_timing: got issues=%0d latency=%0d bad_gaps=%0d N=%0d, required 16 3 0 16", ni, lat, gb, dp[4]);
    end
  endtask

  task automatic test_load_during_run();
    int lat, gb, ni;
    load_basic();
    run_prog(1'b1, lat, gb, ni);
    vectors++;
    if ({done, pc, icount, err} !== {1'b1, 4'd3, 8'd3, 1'b0} || ni !== 3 || gb !== 0 || dp[1] !== 32'd8) begin
      miscompares++;
      $display("FAIL load_during_run: got done=%b pc=%0d icount=%0d err=%b issues=%0d bad_gaps=%0d H=%0d, required 1 3 3 0 3 0 8",
               done, pc, icount, err, ni, gb, dp[1]);
    end
  endtask

  task automatic test_reset_mid_run();
    int base;
    push_expected();
    base = issue_log.size();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 && issue_log.size() < base + 2; i++) tick();
    vectors++;
    if (issue_log.size() < base + 2) begin
      miscompares++;
      $display("FAIL midrun_wait: got %0d issues, required 2", issue_log.size() - base);
    end
    #2 irst_n = 1'b0;
    #1;
    vectors++;
    if ({flag, issue, sw1, sw2, re, n, busy, done, pc, icount, err} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL midrun_reset: got flag=%b issue=%b sw=%b%b re=%0d n=%0d busy=%b done=%b pc=%0d icount=%0d err=%b, required 1 0 00 0 0 0 0 0 0 0",
               flag, issue, sw1, sw2, re, n, busy, done, pc, icount, err);
    end
    exp_q.delete();
    tick();
    tick();
    irst_n = 1'b1;
    tick();
    tick();
    vectors++;
    if ({busy, done, issue, pc} !== {1'b0, 1'b0, 1'b0, 4'd0}) begin
      miscompares++;
      $display("FAIL midrun_idle: got busy=%b done=%b issue=%b pc=%0d, required 0 0 0 0", busy, done, issue, pc);
    end
  endtask

  task automatic test_load_start_same_cycle();
    int lat, gb, ni;
    logic [39:0] w;
    w = mk(2'b11, 1'b0, 1'b0, 4'd1, 32'd2);
    tick();
    load_en = 1'b1; start = 1'b1; load_addr = 4'd2; load_data = w;
    tick();
    load_en = 1'b0; start = 1'b0;
    tick();
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL load_start_idle: got busy=%b done=%b, required 0 0", busy, done);
    end
    model_mem[2] = w;
    for (int i = 0; i < 8; i++) dp[i] = 32'd0;
    run_prog(1'b0, lat, gb, ni);
    vectors++;
    if ({done, pc, icount} !== {1'b1, 4'd3, 8'd3} || ni !== 3 || dp[1] !== 32'd2 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL load_start_word: got done=%b pc=%0d icount=%0d issues=%0d H=%0d pending=%0d, required 1 3 3 3 2 0",
               done, pc, icount, ni, dp[1], exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_restart();
    test_illegal();
    test_end_of_store();
    test_load_during_run();
    test_reset_mid_run();
    test_load_start_same_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
